// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of the single cons/contents memory unit.
// Port 0 is the eval unit, port 1 the host loader/REPL reader. Both see the
// same execute/ready pulse handshake that the memory unit presents.
module mem_arbiter #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned DATA_W  = 24,
    parameter int unsigned FUNC_W  = 2,
    parameter int unsigned TYPE_W  = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c0_execute,
    input  logic [FUNC_W-1:0] c0_func,
    input  logic [ADDR_W-1:0] c0_addr0,
    input  logic [ADDR_W-1:0] c0_addr1,
    input  logic [TYPE_W-1:0] c0_type_info,
    output logic              c0_ready,
    output logic [ADDR_W-1:0] c0_addr,
    output logic [DATA_W-1:0] c0_data,
    input  logic              c1_execute,
    input  logic [FUNC_W-1:0] c1_func,
    input  logic [ADDR_W-1:0] c1_addr0,
    input  logic [ADDR_W-1:0] c1_addr1,
    input  logic [TYPE_W-1:0] c1_type_info,
    output logic              c1_ready,
    output logic [ADDR_W-1:0] c1_addr,
    output logic [DATA_W-1:0] c1_data,
    output logic [FUNC_W-1:0] mem_func,
    output logic              mem_execute,
    output logic [ADDR_W-1:0] mem_addr0,
    output logic [ADDR_W-1:0] mem_addr1,
    output logic [TYPE_W-1:0] mem_type_info,
    input  logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              busy,
    output logic              grant_id,
    output logic              overflow,
    output logic              timeout
);

    localparam int unsigned CNT_W = 10;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {INIT, IDLE, WAIT, RESPOND} state_t;

    typedef struct packed {
        logic [FUNC_W-1:0] func;
        logic [ADDR_W-1:0] addr0;
        logic [ADDR_W-1:0] addr1;
        logic [TYPE_W-1:0] type_info;
    } req_t;

    state_t            state, state_n;
    req_t              req0, req1, sel_c;
    logic              pend0, pend1;
    logic              clr0_c, clr1_c;
    logic              pick_c;
    logic              last_grant, last_grant_n;
    logic [CNT_W-1:0]  cnt, cnt_n;

    logic              resp_c;
    logic [ADDR_W-1:0] resp_addr_c;
    logic [DATA_W-1:0] resp_data_c;

    logic              c0_ready_n, c1_ready_n;
    logic [ADDR_W-1:0] c0_addr_n, c1_addr_n;
    logic [DATA_W-1:0] c0_data_n, c1_data_n;
    logic [FUNC_W-1:0] mem_func_n;
    logic              mem_execute_n;
    logic [ADDR_W-1:0] mem_addr0_n, mem_addr1_n;
    logic [TYPE_W-1:0] mem_type_info_n;
    logic              grant_n, timeout_n;

    // Per-port request latch; a strobe while the port is pending or in flight is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend0    <= 1'b0;
            pend1    <= 1'b0;
            req0     <= '0;
            req1     <= '0;
            overflow <= 1'b0;
        end else begin
            if (clr0_c) pend0 <= 1'b0;
            if (clr1_c) pend1 <= 1'b0;
            if (c0_execute) begin
                if (pend0) begin
                    overflow <= 1'b1;
                end else begin
                    pend0 <= 1'b1;
                    req0  <= '{c0_func, c0_addr0, c0_addr1, c0_type_info};
                end
            end
            if (c1_execute) begin
                if (pend1) begin
                    overflow <= 1'b1;
                end else begin
                    pend1 <= 1'b1;
                    req1  <= '{c1_func, c1_addr0, c1_addr1, c1_type_info};
                end
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n         = state;
        cnt_n           = cnt;
        last_grant_n    = last_grant;
        grant_n         = grant_id;
        timeout_n       = timeout;
        mem_execute_n   = 1'b0;
        mem_func_n      = '0;
        mem_addr0_n     = '0;
        mem_addr1_n     = '0;
        mem_type_info_n = '0;
        c0_ready_n      = 1'b0;
        c1_ready_n      = 1'b0;
        c0_addr_n       = c0_addr;
        c0_data_n       = c0_data;
        c1_addr_n       = c1_addr;
        c1_data_n       = c1_data;
        clr0_c          = 1'b0;
        clr1_c          = 1'b0;
        resp_c          = 1'b0;
        resp_addr_c     = '0;
        resp_data_c     = '0;
        // Sole pending port wins; on a tie the port that was not granted last.
        pick_c          = (pend0 && pend1) ? ~last_grant : pend1;
        sel_c           = pick_c ? req1 : req0;

        case (state)
            INIT: begin
                if (mem_ready) begin
                    c0_ready_n = 1'b1;
                    c1_ready_n = 1'b1;
                    c0_addr_n  = '0;
                    c0_data_n  = '0;
                    c1_addr_n  = '0;
                    c1_data_n  = '0;
                    state_n    = IDLE;
                end
            end
            IDLE: begin
                if (pend0 || pend1) begin
                    mem_execute_n   = 1'b1;
                    mem_func_n      = sel_c.func;
                    mem_addr0_n     = sel_c.addr0;
                    mem_addr1_n     = sel_c.addr1;
                    mem_type_info_n = sel_c.type_info;
                    grant_n         = pick_c;
                    last_grant_n    = pick_c;
                    cnt_n           = '0;
                    state_n         = WAIT;
                end
            end
            WAIT: begin
                // A ready seen while the strobe is still high is stale from before the issue.
                if (mem_ready && !mem_execute) begin
                    resp_c      = 1'b1;
                    resp_addr_c = mem_addr;
                    resp_data_c = mem_data;
                    state_n     = RESPOND;
                end else if (cnt == TO_LAST) begin
                    resp_c      = 1'b1;
                    resp_addr_c = '1;
                    resp_data_c = '0;
                    timeout_n   = 1'b1;
                    state_n     = RESPOND;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            RESPOND: begin
                state_n = IDLE;
            end
            default: begin
                state_n = INIT;
            end
        endcase

        if (resp_c) begin
            if (grant_id) begin
                c1_ready_n = 1'b1;
                c1_addr_n  = resp_addr_c;
                c1_data_n  = resp_data_c;
                clr1_c     = 1'b1;
            end else begin
                c0_ready_n = 1'b1;
                c0_addr_n  = resp_addr_c;
                c0_data_n  = resp_data_c;
                clr0_c     = 1'b1;
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= INIT;
            cnt           <= '0;
            last_grant    <= 1'b1;
            grant_id      <= 1'b0;
            timeout       <= 1'b0;
            busy          <= 1'b0;
            mem_execute   <= 1'b0;
            mem_func      <= '0;
            mem_addr0     <= '0;
            mem_addr1     <= '0;
            mem_type_info <= '0;
            c0_ready      <= 1'b0;
            c1_ready      <= 1'b0;
            c0_addr       <= '0;
            c0_data       <= '0;
            c1_addr       <= '0;
            c1_data       <= '0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            last_grant    <= last_grant_n;
            grant_id      <= grant_n;
            timeout       <= timeout_n;
            busy          <= (state_n == WAIT) || (state_n == RESPOND);
            mem_execute   <= mem_execute_n;
            mem_func      <= mem_func_n;
            mem_addr0     <= mem_addr0_n;
            mem_addr1     <= mem_addr1_n;
            mem_type_info <= mem_type_info_n;
            c0_ready      <= c0_ready_n;
            c1_ready      <= c1_ready_n;
            c0_addr       <= c0_addr_n;
            c0_data       <= c0_data_n;
            c1_addr       <= c1_addr_n;
            c1_data       <= c1_data_n;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural memory unit, per-port response scoreboards,
// and one task per scenario.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int unsigned ADDR_W  = 10;
    localparam int unsigned DATA_W  = 24;
    localparam int unsigned FUNC_W  = 2;
    localparam int unsigned TYPE_W  = 4;
    localparam int unsigned TIMEOUT = 4;

    logic              clk, rst;
    logic              c0_execute, c1_execute;
    logic [FUNC_W-1:0] c0_func, c1_func;
    logic [ADDR_W-1:0] c0_addr0, c0_addr1, c1_addr0, c1_addr1;
    logic [TYPE_W-1:0] c0_type_info, c1_type_info;
    logic              c0_ready, c1_ready;
    logic [ADDR_W-1:0] c0_addr, c1_addr;
    logic [DATA_W-1:0] c0_data, c1_data;
    logic [FUNC_W-1:0] mem_func;
    logic              mem_execute;
    logic [ADDR_W-1:0] mem_addr0, mem_addr1;
    logic [TYPE_W-1:0] mem_type_info;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              busy, grant_id, overflow, timeout;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FUNC_W(FUNC_W),
                  .TYPE_W(TYPE_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .c0_execute(c0_execute), .c0_func(c0_func), .c0_addr0(c0_addr0),
        .c0_addr1(c0_addr1), .c0_type_info(c0_type_info), .c0_ready(c0_ready),
        .c0_addr(c0_addr), .c0_data(c0_data),
        .c1_execute(c1_execute), .c1_func(c1_func), .c1_addr0(c1_addr0),
        .c1_addr1(c1_addr1), .c1_type_info(c1_type_info), .c1_ready(c1_ready),
        .c1_addr(c1_addr), .c1_data(c1_data),
        .mem_func(mem_func), .mem_execute(mem_execute), .mem_addr0(mem_addr0),
        .mem_addr1(mem_addr1), .mem_type_info(mem_type_info),
        .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
        .busy(busy), .grant_id(grant_id), .overflow(overflow), .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } resp_t;

    resp_t             exp_q0[$];
    resp_t             exp_q1[$];
    logic [ADDR_W-1:0] iss_a0_q[$];
    int                iss_cyc_q[$];

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    int rdy0_n  = 0, rdy1_n = 0, rdy0_cyc = 0, rdy1_cyc = 0;
    int mem_delay   = 3;
    bit mem_respond = 1'b1;
    bit pwr_req     = 1'b0;
    int post_nz     = 0;
    int exec_double = 0;
    logic [FUNC_W-1:0] last_func;
    logic [ADDR_W-1:0] last_a1;
    logic [TYPE_W-1:0] last_ti;

    // Reference memory contents: address a returns cell {3, a-1, a+4} at address a+0x100.
    function automatic resp_t mem_model(input logic [ADDR_W-1:0] a);
        resp_t r;
        logic [ADDR_W-1:0] car, cdr;
        car    = a - 10'd1;
        cdr    = a + 10'd4;
        r.addr = a + 10'h100;
        r.data = {4'h3, car, cdr};
        return r;
    endfunction

    // Response monitor followed by the memory unit model, once per falling edge.
    task automatic bfm();
        int cd = 0;
        logic prev_exec = 1'b0;
        logic [ADDR_W-1:0] a = '0;
        resp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (c0_ready) begin
                rdy0_n++; rdy0_cyc = cyc; vectors++;
                if (exp_q0.size() == 0) begin
                    errors++;
                    $display("FAIL c0_unexpected_ready addr=%h data=%h", c0_addr, c0_data);
                end else begin
                    e = exp_q0.pop_front();
                    if (c0_addr !== e.addr || c0_data !== e.data) begin
                        errors++;
                        $display("FAIL c0_resp addr=%h data=%h expected addr=%h data=%h",
                                 c0_addr, c0_data, e.addr, e.data);
                    end
                end
            end
            if (c1_ready) begin
                rdy1_n++; rdy1_cyc = cyc; vectors++;
                if (exp_q1.size() == 0) begin
                    errors++;
                    $display("FAIL c1_unexpected_ready addr=%h data=%h", c1_addr, c1_data);
                end else begin
                    e = exp_q1.pop_front();
                    if (c1_addr !== e.addr || c1_data !== e.data) begin
                        errors++;
                        $display("FAIL c1_resp addr=%h data=%h expected addr=%h data=%h",
                                 c1_addr, c1_data, e.addr, e.data);
                    end
                end
            end
            mem_ready = 1'b0;
            if (rst) begin
                cd = 0;
                prev_exec = 1'b0;
            end else begin
                if (prev_exec) begin
                    if (mem_execute) exec_double++;
                    if (mem_func != 0 || mem_addr0 != 0 || mem_addr1 != 0 || mem_type_info != 0)
                        post_nz++;
                end
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        e = mem_model(a);
                        mem_ready = 1'b1;
                        mem_addr  = e.addr;
                        mem_data  = e.data;
                    end
                end
                if (mem_execute && !prev_exec) begin
                    a = mem_addr0;
                    iss_a0_q.push_back(mem_addr0);
                    iss_cyc_q.push_back(cyc);
                    last_func = mem_func;
                    last_a1   = mem_addr1;
                    last_ti   = mem_type_info;
                    if (mem_respond) cd = mem_delay - 1;
                end
                prev_exec = mem_execute;
                if (pwr_req) begin
                    mem_ready = 1'b1;
                    mem_addr  = 10'h2AA;
                    mem_data  = 24'hABCDEF;
                    pwr_req   = 1'b0;
                end
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic issue(input int port, input logic [ADDR_W-1:0] a0,
                         input logic [FUNC_W-1:0] f, input logic [ADDR_W-1:0] a1,
                         input logic [TYPE_W-1:0] ti);
        if (port == 0) begin
            c0_func = f; c0_addr0 = a0; c0_addr1 = a1; c0_type_info = ti; c0_execute = 1'b1;
        end else begin
            c1_func = f; c1_addr0 = a0; c1_addr1 = a1; c1_type_info = ti; c1_execute = 1'b1;
        end
        step(1);
        c0_execute = 1'b0;
        c1_execute = 1'b0;
    endtask

    task automatic issue_both(input logic [ADDR_W-1:0] a0_p0, input logic [ADDR_W-1:0] a0_p1);
        c0_func = '0; c0_addr0 = a0_p0; c0_addr1 = '0; c0_type_info = '0; c0_execute = 1'b1;
        c1_func = '0; c1_addr0 = a0_p1; c1_addr1 = '0; c1_type_info = '0; c1_execute = 1'b1;
        step(1);
        c0_execute = 1'b0;
        c1_execute = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < budget) begin
            step(1);
            n++;
        end
        vectors++;
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending0=%0d pending1=%0d expected 0 0",
                     exp_q0.size(), exp_q1.size());
        end
        step(2);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(2);
        vectors++;
        if ({c0_ready, c1_ready, mem_execute, busy, grant_id, overflow, timeout} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags got=%b expected 0000000",
                     {c0_ready, c1_ready, mem_execute, busy, grant_id, overflow, timeout});
        end
        vectors++;
        if ({c0_addr, c0_data, c1_addr, c1_data} !== '0) begin
            errors++;
            $display("FAIL reset_resp got=%h %h %h %h expected 0", c0_addr, c0_data, c1_addr, c1_data);
        end
        vectors++;
        if ({mem_func, mem_addr0, mem_addr1, mem_type_info} !== '0) begin
            errors++;
            $display("FAIL reset_mem got=%h %h %h %h expected 0", mem_func, mem_addr0, mem_addr1, mem_type_info);
        end
    endtask

    task automatic test_power_up();
        rst = 1'b0;
        step(5);
        vectors++;
        if (rdy0_n != 0 || rdy1_n != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL init_quiet rdy0=%0d rdy1=%0d busy=%b expected 0 0 0", rdy0_n, rdy1_n, busy);
        end
        exp_q0.push_back('0);
        exp_q1.push_back('0);
        pwr_req = 1'b1;
        step(4);
        vectors++;
        if (rdy0_n != 1 || rdy1_n != 1 || rdy0_cyc != rdy1_cyc) begin
            errors++;
            $display("FAIL power_up_notify rdy0=%0d rdy1=%0d cyc %0d/%0d expected one each same cycle",
                     rdy0_n, rdy1_n, rdy0_cyc, rdy1_cyc);
        end
        vectors++;
        if (busy !== 1'b0 || iss_a0_q.size() != 0) begin
            errors++;
            $display("FAIL power_up_idle busy=%b issues=%0d expected 0 0", busy, iss_a0_q.size());
        end
    endtask

    task automatic test_tie();
        iss_a0_q.delete(); iss_cyc_q.delete();
        exp_q0.push_back(mem_model(10'h010));
        exp_q1.push_back(mem_model(10'h020));
        issue_both(10'h010, 10'h020);
        wait_drain(40);
        vectors++;
        if (!(iss_a0_q.size() == 2 && iss_a0_q[0] == 10'h010 && iss_a0_q[1] == 10'h020)) begin
            errors++;
            $display("FAIL tie_order_p0_first n=%0d first=%h expected 2 010 then 020",
                     iss_a0_q.size(), iss_a0_q.size() > 0 ? iss_a0_q[0] : '0);
        end
        vectors++;
        if (!(iss_cyc_q.size() == 2 && iss_cyc_q[1] - rdy0_cyc == 2)) begin
            errors++;
            $display("FAIL tie_loser_gap got=%0d expected 2",
                     iss_cyc_q.size() == 2 ? iss_cyc_q[1] - rdy0_cyc : -1);
        end
        vectors++;
        if (grant_id !== 1'b1) begin
            errors++;
            $display("FAIL tie_grant_id got=%b expected 1", grant_id);
        end
        // A lone port-0 transaction leaves port 0 as last grant, so the next tie favours port 1.
        exp_q0.push_back(mem_model(10'h030));
        issue(0, 10'h030, '0, '0, '0);
        wait_drain(40);
        iss_a0_q.delete(); iss_cyc_q.delete();
        exp_q0.push_back(mem_model(10'h040));
        exp_q1.push_back(mem_model(10'h050));
        issue_both(10'h040, 10'h050);
        wait_drain(40);
        vectors++;
        if (!(iss_a0_q.size() == 2 && iss_a0_q[0] == 10'h050 && iss_a0_q[1] == 10'h040)) begin
            errors++;
            $display("FAIL tie_order_p1_first n=%0d first=%h expected 2 050 then 040",
                     iss_a0_q.size(), iss_a0_q.size() > 0 ? iss_a0_q[0] : '0);
        end
        vectors++;
        if (!(iss_cyc_q.size() == 2 && iss_cyc_q[1] - rdy1_cyc == 2)) begin
            errors++;
            $display("FAIL tie2_loser_gap got=%0d expected 2",
                     iss_cyc_q.size() == 2 ? iss_cyc_q[1] - rdy1_cyc : -1);
        end
    endtask

    task automatic test_single_read();
        int issue_cyc, r0, r1;
        iss_a0_q.delete(); iss_cyc_q.delete();
        post_nz = 0; exec_double = 0;
        r0 = rdy0_n; r1 = rdy1_n;
        exp_q0.push_back(mem_model(10'h001));
        issue_cyc = cyc;
        issue(0, 10'h001, 2'd1, 10'h155, 4'hA);
        wait_drain(40);
        vectors++;
        if (c0_data !== 24'h300005) begin
            errors++;
            $display("FAIL single_data got=%h expected 300005", c0_data);
        end
        vectors++;
        if (rdy0_n - r0 != 1 || rdy1_n != r1) begin
            errors++;
            $display("FAIL single_ready_count c0=%0d c1=%0d expected 1 0", rdy0_n - r0, rdy1_n - r1);
        end
        vectors++;
        if (!(iss_cyc_q.size() == 1 && iss_cyc_q[0] - issue_cyc == 2 && rdy0_cyc - iss_cyc_q[0] == 3)) begin
            errors++;
            $display("FAIL single_latency issue=%0d resp=%0d expected 2 3",
                     iss_cyc_q.size() == 1 ? iss_cyc_q[0] - issue_cyc : -1,
                     iss_cyc_q.size() == 1 ? rdy0_cyc - iss_cyc_q[0] : -1);
        end
        vectors++;
        if (last_func !== 2'd1 || last_a1 !== 10'h155 || last_ti !== 4'hA) begin
            errors++;
            $display("FAIL single_fields func=%h addr1=%h type=%h expected 1 155 a", last_func, last_a1, last_ti);
        end
        vectors++;
        if (post_nz != 0 || exec_double != 0) begin
            errors++;
            $display("FAIL single_strobe post_nonzero=%0d double=%0d expected 0 0", post_nz, exec_double);
        end
    endtask

    task automatic test_ready_at_limit();
        mem_delay = TIMEOUT;
        exp_q0.push_back(mem_model(10'h0AA));
        issue(0, 10'h0AA, '0, '0, '0);
        wait_drain(40);
        mem_delay = 3;
        vectors++;
        if (timeout !== 1'b0) begin
            errors++;
            $display("FAIL ready_at_limit_timeout got=%b expected 0", timeout);
        end
    endtask

    task automatic test_overflow();
        int r1;
        r1 = rdy1_n;
        vectors++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow_before got=%b expected 0", overflow);
        end
        exp_q1.push_back(mem_model(10'h060));
        issue(1, 10'h060, '0, '0, '0);
        step(1);
        issue(1, 10'h061, '0, '0, '0);
        wait_drain(40);
        step(4);
        vectors++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_flag got=%b expected 1", overflow);
        end
        vectors++;
        if (rdy1_n - r1 != 1) begin
            errors++;
            $display("FAIL overflow_ready_count got=%0d expected 1", rdy1_n - r1);
        end
    endtask

    task automatic test_idle_stray();
        int r0, r1;
        r0 = rdy0_n; r1 = rdy1_n;
        pwr_req = 1'b1;
        step(4);
        vectors++;
        if (rdy0_n != r0 || rdy1_n != r1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_stray_ready c0=%0d c1=%0d busy=%b expected 0 0 0",
                     rdy0_n - r0, rdy1_n - r1, busy);
        end
    endtask

    task automatic test_timeout();
        iss_a0_q.delete(); iss_cyc_q.delete();
        mem_respond = 1'b0;
        exp_q0.push_back('{addr: '1, data: '0});
        issue(0, 10'h070, '0, '0, '0);
        wait_drain(40);
        vectors++;
        if (!(iss_cyc_q.size() == 1 && rdy0_cyc - iss_cyc_q[0] == int'(TIMEOUT))) begin
            errors++;
            $display("FAIL timeout_latency got=%0d expected %0d",
                     iss_cyc_q.size() == 1 ? rdy0_cyc - iss_cyc_q[0] : -1, TIMEOUT);
        end
        vectors++;
        if (timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout_flag got=%b expected 1", timeout);
        end
        mem_respond = 1'b1;
        exp_q0.push_back(mem_model(10'h071));
        issue(0, 10'h071, '0, '0, '0);
        wait_drain(40);
        vectors++;
        if (timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky got=%b expected 1", timeout);
        end
    endtask

    task automatic test_reset_mid_op();
        int r0, r1;
        mem_respond = 1'b0;
        exp_q0.push_back(mem_model(10'h080));
        issue(0, 10'h080, '0, '0, '0);
        step(2);
        vectors++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL midop_busy got=%b expected 1", busy);
        end
        rst = 1'b1;
        #1;
        exp_q0.delete();
        vectors++;
        if (mem_execute !== 1'b0 || busy !== 1'b0 || c0_ready !== 1'b0 || c1_ready !== 1'b0) begin
            errors++;
            $display("FAIL midop_reset exec=%b busy=%b rdy=%b%b expected 0 0 00",
                     mem_execute, busy, c0_ready, c1_ready);
        end
        step(1);
        rst = 1'b0;
        mem_respond = 1'b1;
        iss_a0_q.delete(); iss_cyc_q.delete();
        r0 = rdy0_n; r1 = rdy1_n;
        issue(1, 10'h090, '0, '0, '0);
        step(4);
        vectors++;
        if (rdy0_n != r0 || rdy1_n != r1 || busy !== 1'b0 || iss_a0_q.size() != 0) begin
            errors++;
            $display("FAIL midop_init_hold c0=%0d c1=%0d busy=%b issues=%0d expected 0 0 0 0",
                     rdy0_n - r0, rdy1_n - r1, busy, iss_a0_q.size());
        end
        exp_q0.push_back('0);
        exp_q1.push_back('0);
        exp_q1.push_back(mem_model(10'h090));
        pwr_req = 1'b1;
        wait_drain(40);
        vectors++;
        if (!(iss_a0_q.size() == 1 && iss_a0_q[0] == 10'h090)) begin
            errors++;
            $display("FAIL midop_pending_cleared issues=%0d first=%h expected 1 090",
                     iss_a0_q.size(), iss_a0_q.size() > 0 ? iss_a0_q[0] : '0);
        end
    endtask

    initial begin
        rst = 1'b1;
        c0_execute = 1'b0; c0_func = '0; c0_addr0 = '0; c0_addr1 = '0; c0_type_info = '0;
        c1_execute = 1'b0; c1_func = '0; c1_addr0 = '0; c1_addr1 = '0; c1_type_info = '0;
        mem_ready = 1'b0; mem_addr = '0; mem_data = '0;
        last_func = '0; last_a1 = '0; last_ti = '0;
        fork
            bfm();
        join_none
        test_reset();
        test_power_up();
        test_tie();
        test_single_read();
        test_ready_at_limit();
        test_overflow();
        test_idle_stray();
        test_timeout();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
